// File: rtl/irq_priority_ctrl.sv
// Eight-line priority interrupt controller: captures requests into pending bits, presents the
// highest unmasked one, and tracks it through acknowledge and end-of-interrupt.
module irq_priority_ctrl #(
  parameter int unsigned EDGE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq,
  input  logic [7:0] mask,
  input  logic       en,
  input  logic       ack,
  input  logic       eoi,
  input  logic       clr_ovr,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic       in_service,
  output logic [7:0] ovr
);

  typedef enum logic [1:0] {StIdle, StPresent, StService} state_e;

  state_e     state_q, state_d;
  logic [7:0] irq_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] ovr_q, ovr_d;
  logic [2:0] id_q, id_d;
  logic [7:0] cap;
  logic [7:0] eligible;
  logic [2:0] top_id;
  logic       ack_take;

  assign cap      = (EDGE != 0) ? (irq & ~irq_q) : irq;
  assign eligible = pending_q & ~mask;
  assign ack_take = (state_q == StPresent) && ack;

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) top_id = 3'(i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; ack outranks a dropped enable while presenting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (en && (eligible != '0)) state_d = StPresent;
      StPresent: begin
        if (ack)      state_d = StService;
        else if (!en) state_d = StIdle;
      end
      StService: if (eoi) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    irq_valid  = (state_q == StPresent);
    in_service = (state_q == StService);
    irq_id     = id_q;
    pending    = pending_q;
    ovr        = ovr_q;
  end

  // Datapath next state; a fresh capture beats both the ack clear and clr_ovr.
  always_comb begin
    pending_d = pending_q;
    if (ack_take) pending_d[id_q] = 1'b0;
    pending_d = pending_d | cap;

    ovr_d = clr_ovr ? 8'h00 : ovr_q;
    if (EDGE != 0) ovr_d = ovr_d | (cap & pending_q);

    id_d = id_q;
    if ((state_q == StIdle) && en && (eligible != '0)) id_d = top_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
      ovr_q     <= '0;
      id_q      <= '0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      id_q      <= id_d;
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scoreboard bench for irq_priority_ctrl: a behavioural model predicts every post-edge output
// set, and a negedge monitor compares the DUT against the queued predictions.
module tb_irq_priority_ctrl;

  localparam int unsigned EDGE = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq, mask;
  logic       en, ack, eoi, clr_ovr;
  logic       irq_valid, in_service;
  logic [2:0] irq_id;
  logic [7:0] pending, ovr;

  irq_priority_ctrl #(.EDGE(EDGE)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .mask(mask), .en(en), .ack(ack), .eoi(eoi),
    .clr_ovr(clr_ovr), .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending),
    .in_service(in_service), .ovr(ovr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
    logic [7:0] pend;
    logic       serv;
    logic [7:0] ovr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a request list, the line being handled, and what the consumer is doing.
  bit [7:0] m_prev, m_pend, m_ovr;
  int       m_id;
  bit       m_offered, m_serving;

  function automatic void model_reset();
    m_prev = 0; m_pend = 0; m_ovr = 0; m_id = 0; m_offered = 0; m_serving = 0;
  endfunction

  function automatic void model_step(bit [7:0] i_irq, bit [7:0] i_mask, bit i_en, bit i_ack,
                                     bit i_eoi, bit i_clr);
    bit [7:0] req, np, no;
    int       best;
    for (int i = 0; i < 8; i++) req[i] = (EDGE != 0) ? (i_irq[i] && !m_prev[i]) : i_irq[i];
    np = m_pend;
    no = i_clr ? 8'h00 : m_ovr;
    for (int i = 0; i < 8; i++) if (EDGE != 0 && req[i] && m_pend[i]) no[i] = 1;
    if (m_offered && i_ack) np[m_id] = 0;
    for (int i = 0; i < 8; i++) if (req[i]) np[i] = 1;
    if (m_offered) begin
      if (i_ack) begin m_offered = 0; m_serving = 1; end
      else if (!i_en) m_offered = 0;
    end else if (m_serving) begin
      if (i_eoi) m_serving = 0;
    end else if (i_en) begin
      best = -1;
      for (int i = 7; i >= 0; i--) if (best < 0 && m_pend[i] && !i_mask[i]) best = i;
      if (best >= 0) begin m_id = best; m_offered = 1; end
    end
    m_pend = np; m_ovr = no; m_prev = i_irq;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: every negedge with a prediction queued, compare the whole output set.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("irq_valid", 32'(irq_valid), 32'(e.valid));
      if (e.valid || e.serv) check("irq_id", 32'(irq_id), 32'(e.id));
      check("pending", 32'(pending), 32'(e.pend));
      check("in_service", 32'(in_service), 32'(e.serv));
      check("ovr", 32'(ovr), 32'(e.ovr));
    end
  end

  task automatic cyc(bit [7:0] i_irq, bit [7:0] i_mask, bit i_en, bit i_ack, bit i_eoi,
                     bit i_clr);
    exp_t e;
    irq = i_irq; mask = i_mask; en = i_en; ack = i_ack; eoi = i_eoi; clr_ovr = i_clr;
    @(posedge clk);
    model_step(i_irq, i_mask, i_en, i_ack, i_eoi, i_clr);
    e.valid = m_offered; e.id = 3'(m_id); e.pend = m_pend; e.serv = m_serving; e.ovr = m_ovr;
    sb.push_back(e);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_valid"}, 32'(irq_valid), 0);
    check({tag, "_id"}, 32'(irq_id), 0);
    check({tag, "_pending"}, 32'(pending), 0);
    check({tag, "_in_service"}, 32'(in_service), 0);
    check({tag, "_ovr"}, 32'(ovr), 0);
  endtask

  initial begin
    bit [7:0] ri, rm;
    int       n;
    rst_n = 0; irq = 8'hff; mask = 0; en = 1; ack = 1; eoi = 1; clr_ovr = 0;
    model_reset();
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // A line high through reset release counts as a rising edge.
    cyc(8'h01, 0, 0, 0, 0, 0);
    cyc(8'h00, 0, 1, 0, 0, 0);
    repeat (3) cyc(8'h00, 0, 1, 1, 1, 0);

    // Priority ordering 7, 1, 0 with continuous ack/eoi
    cyc(8'h83, 0, 1, 0, 0, 0);
    repeat (12) cyc(8'h00, 0, 1, 1, 1, 0);
    check("drained_pending", 32'(pending), 0);

    // Mask selection, then unmask while presenting
    cyc(8'h90, 8'h80, 1, 0, 0, 0);
    cyc(8'h00, 8'h80, 1, 0, 0, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    repeat (8) cyc(8'h00, 0, 1, 1, 1, 0);

    // Overrun on line 2, single presentation, then clear
    cyc(8'h04, 0, 1, 0, 0, 0);
    cyc(8'h00, 0, 1, 0, 0, 0);
    cyc(8'h04, 0, 1, 0, 0, 0);
    cyc(8'h00, 0, 1, 0, 0, 0);
    check("ovr_line2", 32'(ovr), 32'h04);
    repeat (4) cyc(8'h00, 0, 1, 1, 1, 0);
    cyc(8'h04, 0, 1, 0, 0, 1);   // set beats clear in the same cycle
    cyc(8'h00, 0, 1, 0, 0, 1);
    repeat (4) cyc(8'h00, 0, 1, 1, 1, 0);

    // Re-request coinciding with ack of line 5
    cyc(8'h20, 0, 1, 0, 0, 0);
    cyc(8'h00, 0, 1, 0, 0, 0);
    cyc(8'h20, 0, 1, 1, 0, 0);
    check("rereq_pending5", 32'(pending[5]), 1);
    cyc(8'h00, 0, 1, 0, 1, 0);
    cyc(8'h00, 0, 1, 0, 0, 0);
    repeat (4) cyc(8'h00, 0, 1, 1, 1, 0);

    // Withdraw on en drop, re-present on en return
    cyc(8'h08, 0, 1, 0, 0, 0);
    cyc(8'h00, 0, 1, 0, 0, 0);
    cyc(8'h00, 0, 0, 0, 0, 0);
    cyc(8'h00, 0, 1, 0, 0, 0);
    cyc(8'h00, 0, 0, 1, 0, 0);   // ack beats en=0
    repeat (3) cyc(8'h00, 0, 1, 0, 1, 0);

    // Randomised traffic
    ri = 0; rm = 0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 2) == 0) ri = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rm = 8'($urandom) & 8'($urandom);
      cyc(ri, rm, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    // Drive into service, then reset asynchronously mid-transaction
    n = 0;
    cyc(8'h00, 0, 1, 0, 0, 0);
    cyc(8'h40, 0, 1, 0, 0, 0);
    while (!m_serving && n < 40) begin
      cyc(8'h00, 0, 1, 1, 0, 0);
      n++;
    end
    check("reached_service", 32'(m_serving), 1);
    @(negedge clk);
    #1 rst_n = 0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    repeat (4) cyc(8'h00, 0, 1, 1, 1, 0);
    cyc(8'h11, 0, 1, 0, 0, 0);
    repeat (8) cyc(8'h00, 0, 1, 1, 1, 0);

    @(negedge clk);
    #1 check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
